// File: rtl/jam_pkg.sv
// Shared definitions for the cost table and the job-assignment search engine.
package jam_pkg;
    localparam int N_WORK = 8;
    localparam int COST_W = 7;
    localparam int SUM_W  = 10;
    localparam int IDX_W  = 3;
    localparam int ADDR_W = 2 * IDX_W;

    typedef logic [COST_W-1:0] cost_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SUM,
        READY
    } state_t;

    localparam cost_t COST_MAX = 7'h7F;

    function automatic cost_t cost_min(input cost_t a, input cost_t b);
        return (a < b) ? a : b;
    endfunction
endpackage

// File: rtl/jam_cost_table_if.sv
// Valid/ready byte stream used to load the cost matrix.
interface jam_cost_table_if;
    import jam_pkg::*;

    logic  LD_VALID;
    cost_t LD_DATA;
    logic  LD_READY;

    modport master (output LD_VALID, output LD_DATA, input  LD_READY);
    modport slave  (input  LD_VALID, input  LD_DATA, output LD_READY);
endinterface

// File: rtl/jam_cost_mem.sv
// 64-entry cost storage: one write port, one registered read port that
// returns zero whenever the read enable is low.
module jam_cost_mem
    import jam_pkg::*;
(
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  cost_t             wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output cost_t             rdata
);
    cost_t mem [0:(1<<ADDR_W)-1];

    // Storage array; contents are not reset.
    always_ff @(posedge CLK) begin
        if (we) mem[waddr] <= wdata;
    end

    // Registered read, forced to zero when not enabled.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) rdata <= '0;
        else       rdata <= re ? mem[raddr] : '0;
    end
endmodule

// File: rtl/jam_cost_table.sv
// Cost matrix source for the search engine: streamed load, row-minimum
// tracking, lower-bound summation and one-cycle (W,J) lookup.
module jam_cost_table
    import jam_pkg::*;
(
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              Reload,
    jam_cost_table_if.slave   ld,
    input  logic [IDX_W-1:0]  W,
    input  logic [IDX_W-1:0]  J,
    output cost_t             Cost,
    output logic              TableReady,
    output logic [SUM_W-1:0]  LowerBound
);
    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
    localparam logic [IDX_W-1:0]  IDX_LAST  = '1;

    state_t                         state, state_nxt;
    logic [ADDR_W-1:0]              addr;
    logic [IDX_W-1:0]               idx;
    logic [SUM_W-1:0]               acc;
    logic [SUM_W-1:0]               sum_nxt;
    logic [N_WORK-1:0][COST_W-1:0]  rowmin;
    logic                           ld_ready;
    logic                           accept;
    logic                           sum_last;
    logic                           rd_en;

    assign ld.LD_READY = ld_ready;
    assign sum_nxt     = acc + SUM_W'(rowmin[idx]);

    // State register.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next state and per-cycle strobes; Reload overrides everything.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        sum_last  = 1'b0;
        rd_en     = 1'b0;
        if (Reload) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE, LOAD: begin
                    if (ld.LD_VALID && ld_ready) begin
                        accept    = 1'b1;
                        state_nxt = (addr == ADDR_LAST) ? SUM : LOAD;
                    end
                end
                SUM: begin
                    if (idx == IDX_LAST) begin
                        sum_last  = 1'b1;
                        state_nxt = READY;
                    end
                end
                READY:   rd_en = 1'b1;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Ready is registered from the next state so it is low out of reset
    // and drops on the same edge that accepts the final beat.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) ld_ready <= 1'b0;
        else       ld_ready <= (state_nxt == IDLE) || (state_nxt == LOAD);
    end

    // Load address, row minimums and the lower-bound accumulator.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            addr       <= '0;
            idx        <= '0;
            acc        <= '0;
            rowmin     <= {N_WORK{COST_MAX}};
            LowerBound <= '0;
            TableReady <= 1'b0;
        end else if (Reload) begin
            addr       <= '0;
            idx        <= '0;
            acc        <= '0;
            rowmin     <= {N_WORK{COST_MAX}};
            LowerBound <= '0;
            TableReady <= 1'b0;
        end else begin
            if (accept) begin
                addr                             <= addr + 1'b1;
                rowmin[addr[ADDR_W-1:IDX_W]]     <= cost_min(rowmin[addr[ADDR_W-1:IDX_W]], ld.LD_DATA);
            end
            if (state == SUM) begin
                acc <= sum_nxt;
                idx <= idx + 1'b1;
                if (sum_last) begin
                    LowerBound <= sum_nxt;
                    TableReady <= 1'b1;
                end
            end
        end
    end

    jam_cost_mem u_mem (
        .CLK   (CLK),
        .RSTn  (RSTn),
        .we    (accept),
        .waddr (addr),
        .wdata (ld.LD_DATA),
        .re    (rd_en),
        .raddr ({W, J}),
        .rdata (Cost)
    );
endmodule

// File: tb/tb_jam_cost_table.sv
// Randomised bench for jam_cost_table with a beat-counting reference model.
module tb_jam_cost_table;
    import jam_pkg::*;

    logic             CLK    = 1'b0;
    logic             RSTn   = 1'b0;
    logic             Reload = 1'b0;
    logic [2:0]       W      = '0;
    logic [2:0]       J      = '0;
    cost_t            Cost;
    logic             TableReady;
    logic [SUM_W-1:0] LowerBound;

    jam_cost_table_if ldif();

    jam_cost_table dut (
        .CLK        (CLK),
        .RSTn       (RSTn),
        .Reload     (Reload),
        .ld         (ldif),
        .W          (W),
        .J          (J),
        .Cost       (Cost),
        .TableReady (TableReady),
        .LowerBound (LowerBound)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Tracks how many beats have landed and how many edges have passed
    // since the 64th; the table is ready 8 edges after the last beat.
    int m_mem [64];
    int nbeats = 0;
    int since  = 0;
    bit m_ld   = 0;
    bit m_tr   = 0;
    int m_lb   = 0;
    int m_cost = 0;

    function automatic int lower_bound();
        int s = 0;
        for (int w = 0; w < 8; w++) begin
            int mn = 127;
            for (int j = 0; j < 8; j++)
                if (m_mem[w*8+j] < mn) mn = m_mem[w*8+j];
            s += mn;
        end
        return s;
    endfunction

    always @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            nbeats = 0; since = 0; m_ld = 0; m_tr = 0; m_lb = 0; m_cost = 0;
        end else if (Reload) begin
            nbeats = 0; since = 0; m_ld = 1; m_tr = 0; m_lb = 0; m_cost = 0;
        end else begin
            m_cost = m_tr ? m_mem[int'(W)*8 + int'(J)] : 0;
            if (m_ld && ldif.LD_VALID) begin
                m_mem[nbeats] = int'(ldif.LD_DATA);
                nbeats++;
            end else if (nbeats == 64 && !m_tr) begin
                since++;
                if (since == 8) begin
                    m_tr = 1;
                    m_lb = lower_bound();
                end
            end
            m_ld = (nbeats < 64);
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge CLK) begin
        check("ld_ready",    int'(ldif.LD_READY), int'(m_ld));
        check("table_ready", int'(TableReady),    int'(m_tr));
        check("lower_bound", int'(LowerBound),    m_lb);
        check("cost",        int'(Cost),          m_cost);
    end

    // ---------------- stimulus helpers ----------------
    int tbl [64];

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input int d, input int gap);
        int budget = 0;
        repeat (gap) begin
            ldif.LD_VALID = 1'b0;
            ldif.LD_DATA  = cost_t'($urandom_range(0, 127));
            tick();
        end
        ldif.LD_VALID = 1'b1;
        ldif.LD_DATA  = cost_t'(d);
        while (!ldif.LD_READY && budget < 20) begin
            tick();
            budget++;
        end
        if (budget >= 20) check("ld_ready_timeout", 0, 1);
        tick();
        ldif.LD_VALID = 1'b0;
    endtask

    task automatic load_table(input int count, input int mingap, input int maxgap);
        for (int i = 0; i < count; i++)
            send(tbl[i], (i == 0) ? 0 : int'($urandom_range(mingap, maxgap)));
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!TableReady && n < 30) begin
            tick();
            n++;
        end
        if (!TableReady) check("table_ready_timeout", 0, 1);
    endtask

    task automatic pulse_reload();
        Reload = 1'b1;
        tick();
        Reload = 1'b0;
    endtask

    task automatic random_lookups(input int n);
        repeat (n) begin
            W = 3'($urandom_range(0, 7));
            J = 3'($urandom_range(0, 7));
            ldif.LD_VALID = 1'($urandom_range(0, 1));
            ldif.LD_DATA  = cost_t'($urandom_range(0, 127));
            tick();
        end
        ldif.LD_VALID = 1'b0;
    endtask

    int lat;

    initial begin
        ldif.LD_VALID = 1'b0;
        ldif.LD_DATA  = '0;
        repeat (3) tick();
        check("rst_ld_ready", int'(ldif.LD_READY), 0);
        check("rst_table_ready", int'(TableReady), 0);
        check("rst_lower_bound", int'(LowerBound), 0);
        check("rst_cost", int'(Cost), 0);
        RSTn = 1'b1;
        tick();

        // Ascending table, back-to-back beats.
        for (int i = 0; i < 64; i++) tbl[i] = i;
        load_table(64, 0, 0);
        check("ld_ready_after_last", int'(ldif.LD_READY), 0);
        wait_ready(lat);
        check("ready_latency", lat, 8);
        check("lb_ascending", int'(LowerBound), 224);
        check("model_lb_ascending", m_lb, 224);

        // Consecutive lookups with LD_VALID pulses that must be ignored.
        W = 3; J = 5; ldif.LD_VALID = 1'b1; ldif.LD_DATA = 7'd1;
        tick();
        check("cost_3_5", int'(Cost), 29);
        W = 7; J = 7;
        tick();
        check("cost_7_7", int'(Cost), 63);
        ldif.LD_VALID = 1'b0;
        check("ready_held", int'(TableReady), 1);
        random_lookups(40);

        // All-127 table with gaps of 1-3 cycles.
        pulse_reload();
        for (int i = 0; i < 64; i++) tbl[i] = 127;
        load_table(64, 1, 3);
        wait_ready(lat);
        check("lb_all_127", int'(LowerBound), 1016);
        check("ready_all_127", int'(TableReady), 1);
        random_lookups(20);

        // Row 2 carries a small minimum among duplicates.
        pulse_reload();
        for (int i = 0; i < 64; i++) tbl[i] = 100;
        tbl[16] = 90; tbl[17] = 17; tbl[18] = 40; tbl[19] = 17;
        tbl[20] = 99; tbl[21] = 5;  tbl[22] = 60; tbl[23] = 70;
        load_table(64, 0, 2);
        wait_ready(lat);
        check("lb_row2", int'(LowerBound), 705);
        check("model_lb_row2", m_lb, 705);
        W = 2; J = 5;
        tick();
        check("cost_2_5", int'(Cost), 5);
        random_lookups(20);

        // Asynchronous reset in the middle of a load.
        pulse_reload();
        for (int i = 0; i < 64; i++) tbl[i] = i;
        load_table(31, 0, 1);
        @(posedge CLK);
        #3;
        RSTn = 1'b0;
        #1;
        check("midrst_ld_ready", int'(ldif.LD_READY), 0);
        check("midrst_table_ready", int'(TableReady), 0);
        check("midrst_lower_bound", int'(LowerBound), 0);
        check("midrst_cost", int'(Cost), 0);
        tick();
        RSTn = 1'b1;
        tick();
        load_table(64, 0, 0);
        wait_ready(lat);
        check("reload_latency", lat, 8);
        check("reload_lb", int'(LowerBound), 224);
        W = 3; J = 5;
        tick();
        check("reload_cost_3_5", int'(Cost), 29);

        // Reload together with a beat: the beat is dropped.
        Reload = 1'b1; ldif.LD_VALID = 1'b1; ldif.LD_DATA = 7'd9;
        tick();
        Reload = 1'b0; ldif.LD_VALID = 1'b0;
        check("drop_table_ready", int'(TableReady), 0);
        check("drop_cost", int'(Cost), 0);
        check("drop_lower_bound", int'(LowerBound), 0);
        check("drop_ld_ready", int'(ldif.LD_READY), 1);
        for (int i = 0; i < 64; i++) tbl[i] = int'($urandom_range(0, 127));
        tbl[0] = 55;
        load_table(64, 0, 2);
        wait_ready(lat);
        W = 0; J = 0;
        tick();
        check("first_beat_addr0", int'(Cost), 55);
        random_lookups(60);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/jam_cost_table.md
Name: jam_cost_table

Overview:
- Cost source that sits directly upstream of the job-assignment search engine. It holds the 8x8 worker/job cost matrix.
- The matrix is loaded once through a valid/ready byte stream. The block then answers (W,J) lookups with exactly one cycle of registered latency, which is the timing the search engine expects on its Cost input.
- During load it also derives a per-worker row minimum and a lower-bound total cost. The search engine uses these for early termination and sanity checks.

Parameters:
- N_WORK, 8, number of workers = number of jobs (matrix is N_WORK x N_WORK; only 8 is supported).
- COST_W, 7, cost entry width in bits.
- SUM_W, 10, width of LowerBound; must hold N_WORK*(2^COST_W-1).

Ports:
- CLK  in  1  single clock, rising edge.
- RSTn  in  1  asynchronous, active-low reset.
- Reload  in  1  one-cycle pulse; discards the current table and returns to IDLE.
- LD_VALID  in  1  load beat valid.
- LD_DATA  in  COST_W  load beat cost value.
- LD_READY  out  1  block accepts a load beat.
- W  in  3  worker index for lookup.
- J  in  3  job index for lookup.
- Cost  out  COST_W  registered lookup result.
- TableReady  out  1  matrix loaded and LowerBound valid.
- LowerBound  out  SUM_W  sum over workers of the row-minimum cost.

Behaviour:
- Reset (RSTn=0, asynchronous): state=IDLE, LD_READY=0, Cost=0, TableReady=0, LowerBound=0, load address=0, all row minimums=all-ones. Memory contents are don't-care.
- States: IDLE, LOAD, SUM, READY.
- IDLE:
  - LD_READY=1.
  - When LD_VALID=1, the beat is accepted as address 0 and the state moves to LOAD.
- LOAD:
  - LD_READY=1. A beat is accepted on any edge with LD_VALID&LD_READY.
  - Address is 6 bits, row-major: addr = W*8+J.
  - Each accepted beat writes mem[addr]<=LD_DATA and sets rowmin[addr[5:3]] <= min(rowmin, LD_DATA).
  - LD_VALID=0 inserts a bubble: address holds and nothing is written.
  - Acceptance of the beat at addr=63 moves the state to SUM. LD_READY drops in the same cycle it registers.
- SUM:
  - LD_READY=0. Runs 8 cycles with idx 0..7; acc <= acc + rowmin[idx]; acc starts at 0.
  - On the edge that adds idx 7: LowerBound<=final sum, TableReady<=1, state moves to READY.
  - TableReady therefore rises 8 edges after the edge that accepted the last beat.
- READY:
  - LD_READY=0, and LD_VALID is ignored.
  - Every edge: Cost<=mem[{W,J}]. This is one-cycle latency: W/J present on edge k gives Cost visible after edge k, for use before edge k+1.
  - Cost is held at 0 in every state other than READY.
- Reload=1 (any state, synchronous):
  - Next state IDLE; address, acc and TableReady clear; rowmin is set to all-ones; LowerBound=0; Cost=0.
  - A beat presented in the same cycle as Reload is dropped.
  - Reload has priority over every other event.
- Reset mid-load or mid-SUM: everything is re-initialised asynchronously. A partial table is never flagged ready.
- Arithmetic: row minimum is an unsigned compare. The sum is unsigned and zero-extended to SUM_W; it cannot overflow at the 8/7/10 widths.
- Out-of-range values cannot occur, because W/J are 3 bits.

Decomposition:
- Shared package jam_pkg holds:
  - constants N_WORK=8, COST_W=7, SUM_W=10;
  - a typedef for the cost word;
  - the state enum {IDLE, LOAD, SUM, READY};
  - the reset value COST_MAX = 7'h7F.
- The search engine imports the same package so the Cost width matches.
- One natural sub-module, jam_cost_mem: 64 x COST_W storage with a single write port and a registered read port. The FSM, row minimums and sum logic stay in the parent.

Test Plan:
- Load mem[W*8+J]=W*8+J back-to-back (64 beats) -> LD_READY low after beat 63; TableReady=1 exactly 8 edges later; LowerBound=224 (0+8+...+56).
- After the ascending load, drive W=3,J=5 then W=7,J=7 on consecutive edges -> Cost=29 then 63, each one edge after its address; LD_VALID pulses in READY are ignored.
- Load all 127 with LD_VALID gaps of 1-3 cycles -> no address skip; LowerBound=1016; TableReady high.
- Load where row 2 = {90,17,40,17,99,5,60,70} and all other entries are 100 -> rowmin[2]=5; LowerBound=705.
- Assert RSTn=0 after beat 30 -> all outputs 0 immediately. Reload the full ascending table -> results match the first scenario.
- In READY, pulse Reload together with LD_VALID, LD_DATA=9 -> the beat is dropped; state IDLE; TableReady=0; Cost=0. The next beat lands at address 0.
